rr_mux_4_1_arbiter: RTL
=======================

Name: rr_mux_4_1_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-input, WIDTH-bit AND-OR multiplexer datapath.
- Shares one downstream valid/ready channel between four requesters.
- Holds the grant for a whole multi-beat packet, from the first beat through the beat with last set.
- Registers the muxed beat in a one-entry output stage, so throughput is one beat per cycle.

Parameters:
- WIDTH, 4, data width of each requester beat and of out_data.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester beat valid; bit i belongs to requester i.
- req_last  input  4  per-requester end-of-packet flag; qualified by req_valid.
- req_data  input  4*WIDTH  packed beats; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  output  4  per-requester accept; at most one bit high per cycle.
- out_valid  output  1  registered beat valid.
- out_data  output  WIDTH  registered muxed beat.
- out_last  output  1  registered end-of-packet flag.
- out_sel  output  2  index of the requester that supplied the current out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - State IDLE; last_grant=3, so requester 0 has first priority.
  - Reset mid-packet drops the lock and discards the staged beat.
- Output stage:
  - load = ~out_valid | out_ready.
  - A requester transfer happens when req_valid[i] & req_ready[i]. The beat appears on out_* the next cycle (latency 1).
  - While out_valid=1 and out_ready=0, all out_* hold and req_ready=0.
- State IDLE:
  - winner = first i with req_valid[i]=1, scanning (last_grant+1) mod 4 upward with wrap 3->0.
  - req_ready[winner] = load; all other bits 0. req_ready is combinational from req_valid, state and load.
  - On transfer: last_grant <= winner. If req_last[winner]=0, go to LOCK with owner=winner; else stay in IDLE.
- State LOCK:
  - Only the owner is considered; req_ready[owner] = load; all others 0, even if valid.
  - Owner valid low: bubble cycle; no re-arbitration and out_valid falls after the stage drains.
  - On a transfer with req_last[owner]=1: go to IDLE. The next arbitration starts from owner+1.
- Datapath:
  - The grant is decoded one-hot. out_data next = OR over i of (req_data[i] & {WIDTH{gnt[i]}}), using only &, | and ~.
  - out_sel is loaded with the binary grant index.
- Simultaneous events:
  - A downstream pop (out_ready=1) and a new transfer in the same cycle keep out_valid=1 with the new beat.
  - No valid requests while load=1: out_valid <= 0.
- Invariants:
  - Popcount(req_ready) <= 1.
  - A packet is never interleaved with another requester's beats.
  - A continuously requesting requester waits at most 3 packets.

Optional Feature:
- Macro RR_ARB_FIXED_PRIO_EN.
- Defined: arbitration in IDLE is fixed priority, lowest index wins. last_grant is not used, and packet locking is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req_valid=4'b1111 with all req_last=1 and out_ready=1 -> grants in order 0,1,2,3,0. out_sel follows the same sequence one cycle after each grant; one beat per cycle.
- Requester 2 sends a 3-beat packet (last on beat 3) while requesters 0 and 1 are valid -> req_ready only to 2 for all 3 beats; the next grant goes to requester 0 (search order 3,0).
- Hold out_ready=0 for 4 cycles while out_valid=1 with out_data=0xA -> out_* stable at 0xA and req_ready=4'b0000 throughout. Then out_ready=1 -> the next beat loads the same cycle.
- In LOCK, owner deasserts valid for 2 cycles while others are valid -> no grant to others, out_valid drops. The owner resumes and finishes its packet.
- Assert rst_n=0 mid-packet with out_valid=1 -> all outputs 0 immediately. After release, requester 0 is granted first.
- Build with RR_ARB_FIXED_PRIO_EN and req_valid=4'b1010 steady, all single-beat -> requester 1 is always granted and requester 3 never is.

Source files
------------

// File: rtl/rr_mux_4_1_arbiter_if.sv
// rr_mux_4_1_arbiter_if
//   Bundles the four-requester input side and the shared downstream
//   valid/ready channel of the round-robin 4:1 mux arbiter.
// Signals:
//   req_valid[3:0]  per-requester beat valid
//   req_last[3:0]   per-requester end-of-packet flag
//   req_data        packed beats, requester i at [i*WIDTH +: WIDTH]
//   req_ready[3:0]  per-requester accept (at most one high)
//   out_valid       registered beat valid
//   out_data        registered muxed beat
//   out_last        registered end-of-packet flag
//   out_sel         index of the requester that supplied out_data
//   out_ready       downstream accept
// Modports:
//   slave  - the arbiter side
//   master - the requester/downstream side (drives requests, consumes output)
interface rr_mux_4_1_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]         req_valid;
    logic [3:0]         req_last;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [1:0]         out_sel;
    logic               out_ready;

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/rr_mux_4_1_arbiter.sv
// rr_mux_4_1_arbiter
//   Round-robin arbiter and sequencer sharing one downstream valid/ready
//   channel between four requesters. The grant is held for a whole packet
//   (first beat through the beat with last set). The selected beat is
//   AND-OR muxed and registered in a one-entry output stage, giving one
//   beat per cycle throughput with latency 1.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - rr_mux_4_1_arbiter_if.slave (request side and output channel)
// Configuration:
//   RR_ARB_FIXED_PRIO_EN - when defined, idle arbitration is fixed priority
//                          (lowest index wins); packet locking is unchanged.
module rr_mux_4_1_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_mux_4_1_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [1:0]       owner_q, owner_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [1:0]       out_sel_q, out_sel_d;

    logic             load;
    logic             found;
    logic             xfer;
    logic [1:0]       idx;
    logic [1:0]       cand;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    always_comb begin
        load         = ~out_valid_q | bus.out_ready;
        found        = 1'b0;
        idx          = 2'd0;
        cand         = 2'd0;
        gnt          = 4'b0000;
        mux_data     = '0;
        mux_last     = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_sel_d    = out_sel_q;

        // Winner selection. Loops run from lowest to highest priority so
        // the final assignment is the highest-priority valid requester.
        if (state_q == IDLE) begin
`ifdef RR_ARB_FIXED_PRIO_EN
            for (int i = 3; i >= 0; i--) begin
                if (bus.req_valid[i]) begin
                    found = 1'b1;
                    idx   = 2'(i);
                end
            end
`else
            for (int k = 4; k >= 1; k--) begin
                cand = last_grant_q + 2'(k);
                if (bus.req_valid[cand]) begin
                    found = 1'b1;
                    idx   = cand;
                end
            end
`endif
        end else begin
            // Locked: only the owner may move; a low valid is a bubble.
            found = bus.req_valid[owner_q];
            idx   = owner_q;
        end

        xfer = found & load;
        if (xfer) begin
            gnt[idx] = 1'b1;
        end

        // AND-OR mux driven by the one-hot grant.
        for (int i = 0; i < 4; i++) begin
            mux_data = mux_data | (bus.req_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
            mux_last = mux_last | (bus.req_last[i] & gnt[i]);
        end

        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_last_d = mux_last;
                out_sel_d  = idx;
            end
        end

        if (xfer) begin
            last_grant_d = idx;
            if (state_q == IDLE) begin
                if (!mux_last) begin
                    state_d = LOCK;
                    owner_d = idx;
                end
            end else if (mux_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            owner_q      <= 2'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_sel_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_sel_q    <= out_sel_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule
